threshold_frame_sched: RTL and testbench

//  Frame-level sequencer for the histogram / last-positive threshold search chain.
//  - Clears the histogram RAM before each frame and gates accumulation to the frame window.
//  - At frame end, launches the threshold search (valid/ready) and collects the 8-bit result.
//  - Publishes the result as the active threshold for the pixel-thresholding stage of the next frame.

---
 rtl/threshold_frame_sched.sv | 141 ++++++++++++++
 tb/tb_threshold_frame_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_frame_sched.sv
// Frame sequencer: clears the histogram, gates accumulation, runs the threshold search and publishes its result.
// Outputs are registered (frame_end->search_valid 1 cycle, result->threshold 1 cycle); search_valid is held until i_search_ready.
module threshold_frame_sched #(
   parameter int          N_BINS         = 256,
   parameter int          TIMEOUT        = 1024,
   parameter logic [7:0]  DEFAULT_THRESH = 8'd128
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_frame_start,
   input  logic        i_frame_end,
   output logic        o_hist_clear,
   output logic [7:0]  o_hist_clear_addr,
   output logic        o_hist_enable,
   output logic        o_search_valid,
   input  logic        i_search_ready,
   input  logic        i_thresh_valid,
   input  logic [7:0]  i_threshold,
   output logic        o_thresh_ready,
   output logic [7:0]  o_threshold,
   output logic        o_threshold_update,
   output logic        o_busy,
   output logic        o_timeout_err,
   output logic [15:0] o_frame_count,
   output logic [7:0]  o_drop_count
);

   localparam int            TW        = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [7:0]    ADDR_LAST = 8'(N_BINS - 1);

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_WAIT_START,
      ST_ACCUM,
      ST_LAUNCH,
      ST_WAIT_RESULT,
      ST_COMMIT
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic            tmo_err_set;
   logic            clr_last;
   logic            search_xfer;
   logic            thresh_xfer;
   logic            tmo_hit;
   logic            drop_evt;

   // Handshake qualifiers use the registered outputs, which track state_q exactly.
   assign clr_last    = o_hist_clear && (o_hist_clear_addr == ADDR_LAST);
   assign search_xfer = o_search_valid && i_search_ready;
   assign thresh_xfer = o_thresh_ready && i_thresh_valid;
   assign tmo_hit     = (tmo_cnt_q == TMO_LAST);
   assign drop_evt    = i_frame_start &&
                        (state_q inside {ST_CLEAR, ST_LAUNCH, ST_WAIT_RESULT, ST_COMMIT});

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= ST_CLEAR;
         tmo_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tmo_cnt_d   = tmo_cnt_q;
      tmo_err_set = 1'b0;
      case (state_q)
         ST_CLEAR:      if (clr_last) state_d = ST_WAIT_START;
         ST_WAIT_START: if (i_frame_start) state_d = ST_ACCUM;
         ST_ACCUM: begin
            if (i_frame_end) begin
               state_d   = ST_LAUNCH;
               tmo_cnt_d = '0;
            end
         end
         ST_LAUNCH: begin
            // Saturates so a late search handshake still times out on the next cycle.
            if (!tmo_hit) tmo_cnt_d = tmo_cnt_q + TW'(1);
            if (search_xfer) begin
               state_d = ST_WAIT_RESULT;
            end else if (tmo_hit) begin
               state_d     = ST_CLEAR;
               tmo_err_set = 1'b1;
            end
         end
         ST_WAIT_RESULT: begin
            if (!tmo_hit) tmo_cnt_d = tmo_cnt_q + TW'(1);
            if (thresh_xfer) begin
               state_d = ST_COMMIT;
            end else if (tmo_hit) begin
               state_d     = ST_CLEAR;
               tmo_err_set = 1'b1;
            end
         end
         ST_COMMIT:     state_d = ST_CLEAR;
         default:       state_d = ST_CLEAR;
      endcase
   end

   // Outputs are loaded from the next state so they describe the state being entered.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_hist_clear       <= 1'b0;
         o_hist_clear_addr  <= '0;
         o_hist_enable      <= 1'b0;
         o_search_valid     <= 1'b0;
         o_thresh_ready     <= 1'b0;
         o_threshold        <= DEFAULT_THRESH;
         o_threshold_update <= 1'b0;
         o_busy             <= 1'b1;
         o_timeout_err      <= 1'b0;
         o_frame_count      <= '0;
         o_drop_count       <= '0;
      end else begin
         o_hist_clear       <= (state_d == ST_CLEAR);
         if ((state_d == ST_CLEAR) && (state_q == ST_CLEAR) && o_hist_clear)
            o_hist_clear_addr <= o_hist_clear_addr + 8'd1;
         else
            o_hist_clear_addr <= '0;
         o_hist_enable      <= (state_d == ST_ACCUM);
         o_search_valid     <= (state_d == ST_LAUNCH);
         o_thresh_ready     <= (state_d == ST_WAIT_RESULT);
         o_threshold_update <= (state_d == ST_COMMIT);
         o_busy             <= (state_d != ST_WAIT_START);
         if (thresh_xfer)
            o_threshold <= i_threshold;
         if (state_d == ST_COMMIT)
            o_frame_count <= o_frame_count + 16'd1;
         if (tmo_err_set)
            o_timeout_err <= 1'b1;
         if (drop_evt && (o_drop_count != 8'hFF))
            o_drop_count <= o_drop_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_threshold_frame_sched.sv
// Directed-plus-random bench for threshold_frame_sched; expectations come from frame-level bookkeeping.
module tb_threshold_frame_sched;

   localparam int TMO = 64;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_frame_start = 1'b0;
   logic        i_frame_end = 1'b0;
   logic        i_search_ready = 1'b0;
   logic        i_thresh_valid = 1'b0;
   logic [7:0]  i_threshold = 8'd0;
   logic        o_hist_clear;
   logic [7:0]  o_hist_clear_addr;
   logic        o_hist_enable;
   logic        o_search_valid;
   logic        o_thresh_ready;
   logic [7:0]  o_threshold;
   logic        o_threshold_update;
   logic        o_busy;
   logic        o_timeout_err;
   logic [15:0] o_frame_count;
   logic [7:0]  o_drop_count;

   int   total = 0;
   int   bad = 0;
   int   exp_fc = 0;
   int   exp_drop = 0;
   int   exp_err = 0;
   int   exp_thr = 128;

   threshold_frame_sched #(
      .N_BINS(256), .TIMEOUT(TMO), .DEFAULT_THRESH(8'd128)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
      .o_hist_clear(o_hist_clear), .o_hist_clear_addr(o_hist_clear_addr),
      .o_hist_enable(o_hist_enable),
      .o_search_valid(o_search_valid), .i_search_ready(i_search_ready),
      .i_thresh_valid(i_thresh_valid), .i_threshold(i_threshold),
      .o_thresh_ready(o_thresh_ready),
      .o_threshold(o_threshold), .o_threshold_update(o_threshold_update),
      .o_busy(o_busy), .o_timeout_err(o_timeout_err),
      .o_frame_count(o_frame_count), .o_drop_count(o_drop_count)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (o_busy !== 1'b0 && n < 2000) begin
         step();
         n++;
      end
      check(tag, o_busy, 0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_thr"},    o_threshold, 128);
      check({tag, "_busy"},   o_busy, 1);
      check({tag, "_clr"},    {o_hist_clear, o_hist_clear_addr}, 0);
      check({tag, "_hs"},     {o_hist_enable, o_search_valid, o_thresh_ready, o_threshold_update}, 0);
      check({tag, "_err"},    o_timeout_err, 0);
      check({tag, "_fc"},     o_frame_count, 0);
      check({tag, "_drop"},   o_drop_count, 0);
   endtask

   // Runs one frame from WAIT_START; without a result the search is left to time out.
   task automatic run_frame(input int len, input int rdy_dly, input int res_dly,
                            input logic [7:0] val, input bit do_result);
      int en_cnt = 0;
      int sv_cnt = 0;
      int idx = 0;
      i_frame_start = 1'b1;
      i_frame_end   = 1'($urandom_range(0, 1));
      step();
      i_frame_start = 1'b0;
      i_frame_end   = 1'b0;
      for (int j = 1; j <= len; j++) begin
         if (o_hist_enable === 1'b1) en_cnt++;
         if (j == len) begin
            i_frame_end   = 1'b1;
            i_frame_start = 1'($urandom_range(0, 1));
         end else if (j == len / 2) begin
            i_frame_start = 1'b1;
         end
         step();
         i_frame_start = 1'b0;
         i_frame_end   = 1'b0;
      end
      check("hist_enable_cycles", en_cnt, len);
      check("hist_enable_off", o_hist_enable, 0);
      check("drop_in_accum", o_drop_count, exp_drop);
      for (int j = 0; j < rdy_dly; j++) begin
         if (o_search_valid === 1'b1) sv_cnt++;
         i_thresh_valid = 1'($urandom_range(0, 1));
         i_threshold    = 8'($urandom);
         step();
         idx++;
      end
      i_thresh_valid = 1'b0;
      check("search_valid_held", sv_cnt, rdy_dly);
      check("search_valid_at_xfer", o_search_valid, 1);
      i_search_ready = 1'b1;
      step();
      idx++;
      i_search_ready = 1'b0;
      check("search_valid_after_xfer", o_search_valid, 0);
      check("thresh_ready", o_thresh_ready, 1);
      check("thr_before_result", o_threshold, exp_thr);
      if (do_result) begin
         repeat (res_dly) step();
         check("no_update_before", o_threshold_update, 0);
         i_thresh_valid = 1'b1;
         i_threshold    = val;
         step();
         i_thresh_valid = 1'b0;
         i_threshold    = 8'($urandom);
         exp_thr = int'(val);
         exp_fc  = (exp_fc + 1) & 16'hFFFF;
         check("commit_thr", o_threshold, exp_thr);
         check("commit_update", o_threshold_update, 1);
         check("commit_fc", o_frame_count, exp_fc);
         check("commit_ready_off", o_thresh_ready, 0);
         step();
         check("post_commit_update", o_threshold_update, 0);
         check("post_commit_clr", {o_hist_clear, o_hist_clear_addr}, {1'b1, 8'd0});
      end else begin
         while (idx < TMO - 1) begin
            step();
            idx++;
         end
         check("err_before_limit", o_timeout_err, exp_err);
         step();
         exp_err = 1;
         check("err_at_limit", o_timeout_err, 1);
         check("tmo_clr", {o_hist_clear, o_hist_clear_addr}, {1'b1, 8'd0});
         check("tmo_thr", o_threshold, exp_thr);
         check("tmo_no_update", o_threshold_update, 0);
         check("tmo_fc", o_frame_count, exp_fc);
      end
   endtask

   initial begin
      int en_hits;
      logic [7:0] rv;

      // Reset values and the first clear sweep, with one frame start dropped mid-sweep.
      repeat (3) step();
      check_reset_vals("reset");
      i_reset = 1'b0;
      for (int i = 0; i < 256; i++) begin
         step();
         i_frame_start = 1'b0;
         check("clear_sweep", {o_hist_clear, o_hist_clear_addr, o_busy}, {1'b1, i[7:0], 1'b1});
         if (i == 10) i_frame_start = 1'b1;
      end
      exp_drop = 1;
      step();
      check("idle_busy", o_busy, 0);
      check("idle_clr", o_hist_clear, 0);
      check("drop_in_clear", o_drop_count, exp_drop);

      // Search result never arrives: abort, then a normal frame still completes.
      run_frame(20, 4, 0, 8'd0, 1'b0);
      wait_idle("idle_after_tmo");
      run_frame(100, 3, 5, 8'd42, 1'b1);
      wait_idle("idle_after_nominal");
      run_frame(40, 10, 2, 8'($urandom), 1'b1);
      wait_idle("idle_after_stall");

      for (int k = 0; k < 6; k++) begin
         rv = (k == 0) ? 8'd0 : 8'($urandom);
         run_frame($urandom_range(1, 150), $urandom_range(0, 10), $urandom_range(0, 20), rv, 1'b1);
         wait_idle("idle_random");
      end

      // Frame starts held through LAUNCH timeout and CLEAR: drop counter saturates.
      i_frame_start = 1'b1;
      step();
      i_frame_start = 1'b0;
      repeat (4) step();
      i_frame_end = 1'b1;
      step();
      i_frame_end = 1'b0;
      i_frame_start = 1'b1;
      en_hits = 0;
      for (int j = 0; j < 300; j++) begin
         step();
         if (o_hist_enable !== 1'b0) en_hits++;
         if (j == 99) check("drop_mid", o_drop_count, exp_drop + 100);
      end
      i_frame_start = 1'b0;
      exp_drop = 255;
      exp_err  = 1;
      check("drop_saturated", o_drop_count, exp_drop);
      check("enable_while_dropping", en_hits, 0);
      check("err_sticky", o_timeout_err, exp_err);
      wait_idle("idle_after_drops");
      check("drop_still_sat", o_drop_count, exp_drop);

      // Reset while waiting for a result; a late result must be discarded.
      i_frame_start = 1'b1;
      step();
      i_frame_start = 1'b0;
      repeat (3) step();
      i_frame_end = 1'b1;
      step();
      i_frame_end = 1'b0;
      i_search_ready = 1'b1;
      step();
      i_search_ready = 1'b0;
      check("pre_reset_wait_result", o_thresh_ready, 1);
      i_reset = 1'b1;
      step();
      step();
      exp_thr = 128; exp_fc = 0; exp_drop = 0; exp_err = 0;
      check_reset_vals("midreset");
      i_reset = 1'b0;
      step();
      check("rst_clear_addr0", {o_hist_clear, o_hist_clear_addr}, {1'b1, 8'd0});
      i_thresh_valid = 1'b1;
      i_threshold    = 8'd9;
      step();
      i_thresh_valid = 1'b0;
      check("late_result_ready", o_thresh_ready, 0);
      check("late_result_thr", o_threshold, exp_thr);
      check("late_result_update", o_threshold_update, 0);
      check("rst_clear_addr1", {o_hist_clear, o_hist_clear_addr}, {1'b1, 8'd1});
      wait_idle("idle_after_reset");
      check("final_fc", o_frame_count, exp_fc);
      check("final_thr", o_threshold, exp_thr);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
